iob_ethmac_mii_loopback: RTL and testbench
==========================================

Name: iob_ethmac_mii_loopback

Overview:
- Single-clock MII loopback PHY model on the ethernet side of the MAC simulation/FPGA-test harness.
- Captures one transmitted frame from the MAC's MII TX pins (txd/tx_en/tx_er) into a nibble buffer.
- Replays it on the MAC's MII RX pins (rxd/rx_dv/rx_er) after an enforced inter-frame gap plus a programmable delay.
- Replaces a bare registered TX-to-RX wire, so RX-path timing, IFG handling and error paths can be exercised.

Parameters:
- BUF_ADDR_W, 12, log2 of buffer depth in nibbles; 4096 nibbles holds a 1518-byte frame plus preamble/SFD.
- DELAY_W, 8, width of cfg_delay_i.
- CNT_W, 16, width of the frame and drop counters.

Ports:
- clk_i  in  1  ethernet clock; MII TX and RX both run on it.
- arst_i  in  1  asynchronous, active-high reset.
- cfg_delay_i  in  DELAY_W  extra replay delay in cycles; sampled on the first cycle tx_en is low after capture.
- mii_txd_i  in  4  TX nibble from the MAC.
- mii_tx_en_i  in  1  TX enable from the MAC.
- mii_tx_er_i  in  1  TX error from the MAC.
- mii_rxd_o  out  4  RX nibble to the MAC; registered.
- mii_rx_dv_o  out  1  RX data valid; registered.
- mii_rx_er_o  out  1  RX error; registered.
- busy_o  out  1  high in any state other than IDLE.
- frame_cnt_o  out  CNT_W  frames fully replayed; saturating.
- drop_cnt_o  out  CNT_W  frames discarded; saturating.

Behaviour:
- Clock and reset: one clock, clk_i. arst_i is asynchronous and active-high.
- Reset: all outputs 0, state IDLE, length counter 0. Buffer contents are don't-care.
- Reset mid-operation: outputs drop to 0 immediately (asynchronous); an in-flight frame is lost and is not counted.
- Buffer: 2^BUF_ADDR_W x 5 bits, simple dual-port, synchronous read with 1-cycle latency. Each entry is {tx_er, txd}.
- FSM states: IDLE, CAPTURE, DISCARD, WAIT, REPLAY.
- IDLE:
  - tx_en=1 writes nibble to address 0, sets len=1, goes to CAPTURE.
- CAPTURE:
  - While tx_en=1: write at address len, len++.
  - If tx_en=1 while len == 2^BUF_ADDR_W (overflow): go to DISCARD and do not write.
  - When tx_en=0: go to WAIT with wait_cnt = max(cfg_delay_i, 24). 24 nibbles is the 96-bit-time minimum IFG.
- DISCARD:
  - Stays until tx_en=0, then drop_cnt++ and go to IDLE.
- WAIT:
  - wait_cnt decrements each cycle.
  - When wait_cnt reaches 1, read address 0 is issued; next cycle the state is REPLAY.
- REPLAY:
  - Reads proceed sequentially.
  - rx_dv is high for exactly len contiguous cycles with rxd/rx_er equal to the stored entries in order.
  - On the last nibble, frame_cnt++ and go to IDLE; rx_dv is low the following cycle.
- Latency: if tx_en is first sampled low at cycle T, the first rx_dv=1 cycle is T+D+2, where D is the effective delay (D ≥ 24).
- TX activity during WAIT or REPLAY:
  - A rising edge of tx_en increments drop_cnt once. That frame is ignored entirely.
  - The pending or in-progress replay is unaffected.
  - When the replay finishes while tx_en is still high, the FSM goes to DISCARD for the remainder of that frame and does not count it again.
- tx_er with tx_en=0 is ignored.
- Counters saturate at all-ones. Simultaneous increments cannot occur because each increment is tied to a distinct state transition.

Optional Feature:
- Macro: ETHMAC_LB_ERR_INJ_EN.
- Enabled:
  - Adds ports err_en_i (in, 1) and err_idx_i (in, BUF_ADDR_W), both sampled at the WAIT→REPLAY transition.
  - If err_en_i=1 and err_idx_i < len, the replayed nibble at index err_idx_i is output as rxd XOR 4'hF with rx_er=1.
  - All other nibbles are unchanged.
- Disabled: ports are absent and rx_er is always the stored tx_er.

Decomposition:
- Shared package holds:
  - the FSM state encoding localparams;
  - MII_MIN_IFG = 24;
  - ENTRY_W = 5.
- One natural sub-module: iob_ethmac_lb_buf, a simple dual-port synchronous-read RAM (write port driven by capture, read port by replay). The existing team dual-port RAM may be used instead.

Test Plan:
- 64-byte frame (128 nibbles, tx_en high 128 cycles), cfg_delay_i=0 → rx_dv rises at T+26, stays high 128 cycles, data matches bit-exact, frame_cnt_o=1, busy_o low afterwards.
- Same frame with cfg_delay_i=100 → rx_dv rises at T+102. With cfg_delay_i=10 → clamped, rises at T+26.
- tx_er=1 on nibble index 10 → rx_er=1 only on replayed nibble 10, all data still correct.
- Overflow: tx_en held high for 4100 cycles (BUF_ADDR_W=12) → no rx_dv, drop_cnt_o=1, FSM back in IDLE.
- Second frame started during replay of the first → first replay intact, frame_cnt_o=1, drop_cnt_o=1. A third frame started later is replayed normally.
- arst_i pulsed mid-replay → rx_dv/rxd/rx_er go to 0 immediately and both counters read 0. With ETHMAC_LB_ERR_INJ_EN and err_idx_i=5 → nibble 5 is inverted with rx_er=1.

Source files
------------

// File: rtl/iob_ethmac_mii_loopback_pkg.sv
// Shared definitions for the MII loopback PHY model: FSM encoding, IFG minimum, buffer entry width.
package iob_ethmac_mii_loopback_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_DISCARD = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_REPLAY  = 3'd4;

    // 96 bit times of inter-frame gap expressed in MII nibbles.
    localparam int MII_MIN_IFG = 24;

    // Buffer entry is {tx_er, txd}.
    localparam int ENTRY_W = 5;

endpackage

// File: rtl/iob_ethmac_lb_buf.sv
// Simple dual-port RAM with synchronous 1-cycle read, holding one captured MII frame.
module iob_ethmac_lb_buf
    import iob_ethmac_mii_loopback_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = ENTRY_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_ethmac_mii_loopback.sv
// MII loopback PHY model: captures one TX frame, replays it on RX after IFG plus programmable delay.
// Optional error injection on one replayed nibble is enabled by defining ETHMAC_LB_ERR_INJ_EN.
module iob_ethmac_mii_loopback
    import iob_ethmac_mii_loopback_pkg::*;
#(
    parameter int BUF_ADDR_W = 12,
    parameter int DELAY_W    = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
`ifdef ETHMAC_LB_ERR_INJ_EN
    input  logic                  err_en_i,
    input  logic [BUF_ADDR_W-1:0] err_idx_i,
`endif
    input  logic [DELAY_W-1:0]    cfg_delay_i,
    input  logic [3:0]            mii_txd_i,
    input  logic                  mii_tx_en_i,
    input  logic                  mii_tx_er_i,
    output logic [3:0]            mii_rxd_o,
    output logic                  mii_rx_dv_o,
    output logic                  mii_rx_er_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      frame_cnt_o,
    output logic [CNT_W-1:0]      drop_cnt_o
);

    localparam logic [BUF_ADDR_W:0] BUF_DEPTH = {1'b1, {BUF_ADDR_W{1'b0}}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [DELAY_W-1:0] eff_delay(input logic [DELAY_W-1:0] d);
        return (d < DELAY_W'(MII_MIN_IFG)) ? DELAY_W'(MII_MIN_IFG) : d;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [BUF_ADDR_W:0]   len_q, len_d;
    logic [DELAY_W-1:0]    wait_q, wait_d;
    logic [BUF_ADDR_W-1:0] rep_idx_q, rep_idx_d;
    logic                  skip_drop_q, skip_drop_d;
    logic                  tx_en_prev_q;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [3:0]            rxd_q, rxd_d;
    logic                  rx_dv_q, rx_dv_d;
    logic                  rx_er_q, rx_er_d;
`ifdef ETHMAC_LB_ERR_INJ_EN
    logic                  err_en_q, err_en_d;
    logic [BUF_ADDR_W-1:0] err_idx_q, err_idx_d;
`endif

    logic                  buf_we;
    logic [BUF_ADDR_W-1:0] buf_waddr;
    logic [ENTRY_W-1:0]    buf_wdata;
    logic                  buf_re;
    logic [BUF_ADDR_W-1:0] buf_raddr;
    logic [ENTRY_W-1:0]    buf_rdata;
    logic                  tx_rise;

    assign tx_rise = mii_tx_en_i & ~tx_en_prev_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wait_d      = wait_q;
        rep_idx_d   = rep_idx_q;
        skip_drop_d = skip_drop_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        rxd_d       = 4'd0;
        rx_dv_d     = 1'b0;
        rx_er_d     = 1'b0;
        buf_we      = 1'b0;
        buf_waddr   = len_q[BUF_ADDR_W-1:0];
        buf_wdata   = {mii_tx_er_i, mii_txd_i};
        buf_re      = 1'b0;
        buf_raddr   = rep_idx_q + BUF_ADDR_W'(1);
`ifdef ETHMAC_LB_ERR_INJ_EN
        err_en_d    = err_en_q;
        err_idx_d   = err_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mii_tx_en_i) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    len_d     = (BUF_ADDR_W+1)'(1);
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (mii_tx_en_i) begin
                    if (len_q == BUF_DEPTH) begin
                        skip_drop_d = 1'b0;
                        state_d     = ST_DISCARD;
                    end else begin
                        buf_we = 1'b1;
                        len_d  = len_q + (BUF_ADDR_W+1)'(1);
                    end
                end else begin
                    wait_d  = eff_delay(cfg_delay_i);
                    state_d = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (!mii_tx_en_i) begin
                    if (!skip_drop_q) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end
                    skip_drop_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (tx_rise) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end
                if (wait_q <= DELAY_W'(1)) begin
                    buf_re    = 1'b1;
                    buf_raddr = '0;
                    rep_idx_d = '0;
                    state_d   = ST_REPLAY;
`ifdef ETHMAC_LB_ERR_INJ_EN
                    err_en_d  = err_en_i;
                    err_idx_d = err_idx_i;
`endif
                end else begin
                    wait_d = wait_q - DELAY_W'(1);
                end
            end
            ST_REPLAY: begin
                if (tx_rise) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end
                rx_dv_d = 1'b1;
                rxd_d   = buf_rdata[3:0];
                rx_er_d = buf_rdata[4];
`ifdef ETHMAC_LB_ERR_INJ_EN
                if (err_en_q && (rep_idx_q == err_idx_q)) begin
                    rxd_d   = buf_rdata[3:0] ^ 4'hF;
                    rx_er_d = 1'b1;
                end
`endif
                if ({1'b0, rep_idx_q} == len_q - (BUF_ADDR_W+1)'(1)) begin
                    // A frame that arrived during wait/replay is still on the wire: swallow its tail, already counted.
                    frame_cnt_d = sat_inc(frame_cnt_q);
                    skip_drop_d = mii_tx_en_i;
                    state_d     = mii_tx_en_i ? ST_DISCARD : ST_IDLE;
                end else begin
                    buf_re    = 1'b1;
                    rep_idx_d = rep_idx_q + BUF_ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            wait_q       <= '0;
            rep_idx_q    <= '0;
            skip_drop_q  <= 1'b0;
            tx_en_prev_q <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            rxd_q        <= 4'd0;
            rx_dv_q      <= 1'b0;
            rx_er_q      <= 1'b0;
`ifdef ETHMAC_LB_ERR_INJ_EN
            err_en_q     <= 1'b0;
            err_idx_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wait_q       <= wait_d;
            rep_idx_q    <= rep_idx_d;
            skip_drop_q  <= skip_drop_d;
            tx_en_prev_q <= mii_tx_en_i;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            rxd_q        <= rxd_d;
            rx_dv_q      <= rx_dv_d;
            rx_er_q      <= rx_er_d;
`ifdef ETHMAC_LB_ERR_INJ_EN
            err_en_q     <= err_en_d;
            err_idx_q    <= err_idx_d;
`endif
        end
    end

    iob_ethmac_lb_buf #(
        .ADDR_W (BUF_ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (buf_wdata),
        .re_i    (buf_re),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    assign mii_rxd_o   = rxd_q;
    assign mii_rx_dv_o = rx_dv_q;
    assign mii_rx_er_o = rx_er_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_iob_ethmac_mii_loopback.sv
// Scoreboard bench for iob_ethmac_mii_loopback: captured nibbles are queued and checked on RX replay.
module tb_iob_ethmac_mii_loopback;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [7:0]  cfg_delay = 8'd0;
    logic [3:0]  txd = 4'd0;
    logic        tx_en = 1'b0;
    logic        tx_er = 1'b0;
    logic [3:0]  rxd;
    logic        rx_dv;
    logic        rx_er;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        inj_en = 1'b0;
    logic [11:0] inj_idx = 12'd0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int exp_frames = 0;
    int exp_drops = 0;

    logic [4:0] exp_q[$];
    int         start_q[$];
    int         blen_q[$];
    bit         mon_prev_dv = 1'b0;
    int         mon_burst = 0;
    int         mon_s;
    int         mon_l;
    logic [4:0] mon_e;

    iob_ethmac_mii_loopback dut (
        .clk_i       (clk),
        .arst_i      (arst),
`ifdef ETHMAC_LB_ERR_INJ_EN
        .err_en_i    (inj_en),
        .err_idx_i   (inj_idx),
`endif
        .cfg_delay_i (cfg_delay),
        .mii_txd_i   (txd),
        .mii_tx_en_i (tx_en),
        .mii_tx_er_i (tx_er),
        .mii_rxd_o   (rxd),
        .mii_rx_dv_o (rx_dv),
        .mii_rx_er_o (rx_er),
        .busy_o      (busy),
        .frame_cnt_o (frame_cnt),
        .drop_cnt_o  (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RX monitor: start cycle, per-nibble content and burst length against the scoreboard.
    always @(negedge clk) begin
        if (rx_dv) begin
            if (!mon_prev_dv) begin
                vectors++;
                if (start_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rx_start: unexpected rx_dv at cycle %0d", cyc);
                end else begin
                    mon_s = start_q.pop_front();
                    if (cyc !== mon_s) begin
                        miscompares++;
                        $display("FAIL rx_start: rx_dv rose at cycle %0d, expected %0d", cyc, mon_s);
                    end
                end
                mon_burst = 0;
            end
            mon_burst++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rx_nibble: extra nibble {er,d}=%h at cycle %0d", {rx_er, rxd}, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rx_er, rxd} !== mon_e) begin
                    miscompares++;
                    $display("FAIL rx_nibble: got {er,d}=%h, expected %h (burst idx %0d)", {rx_er, rxd}, mon_e, mon_burst - 1);
                end
            end
        end else if (mon_prev_dv) begin
            vectors++;
            mon_l = (blen_q.size() != 0) ? blen_q.pop_front() : -1;
            if (mon_burst !== mon_l) begin
                miscompares++;
                $display("FAIL rx_len: burst of %0d nibbles, expected %0d", mon_burst, mon_l);
            end
        end
        mon_prev_dv = rx_dv;
    end

    task automatic send_frame(input int n, input int er_idx, input int dly, input bit expect_it);
        logic [3:0] d;
        logic       er;
        int         eff;
        cfg_delay = 8'(dly);
        eff = (dly < 24) ? 24 : dly;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = 4'($urandom_range(0, 15));
            er = (i == er_idx);
            tx_en = 1'b1;
            txd = d;
            tx_er = er;
            if (expect_it) begin
                if (inj_en && (i == int'(inj_idx))) exp_q.push_back({1'b1, d ^ 4'hF});
                else exp_q.push_back({er, d});
            end
        end
        @(negedge clk);
        tx_en = 1'b0;
        tx_er = 1'b0;
        txd = 4'd0;
        if (expect_it) begin
            start_q.push_back(cyc + eff + 2);
            blen_q.push_back(n);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (k < budget && (busy || rx_dv || exp_q.size() != 0)) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (busy || rx_dv || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_idle: busy=%0b rx_dv=%0b pending=%0d after %0d cycles, expected idle", name, busy, rx_dv, exp_q.size(), budget);
        end
    endtask

    task automatic wait_rx_dv(input string name, input int budget);
        int k = 0;
        while (k < budget && !rx_dv) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (!rx_dv) begin
            miscompares++;
            $display("FAIL %s_dv_wait: rx_dv=%0b after %0d cycles, expected 1", name, rx_dv, budget);
        end
    endtask

    task automatic check_counters(input string name);
        vectors++;
        if (frame_cnt !== 16'(exp_frames)) begin
            miscompares++;
            $display("FAIL %s_frame_cnt: got %0d, expected %0d", name, frame_cnt, exp_frames);
        end
        vectors++;
        if (drop_cnt !== 16'(exp_drops)) begin
            miscompares++;
            $display("FAIL %s_drop_cnt: got %0d, expected %0d", name, drop_cnt, exp_drops);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy: got %0b, expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_dv, rxd, rx_er} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_rx: got {dv,d,er}=%h, expected 0", {rx_dv, rxd, rx_er});
        end
        check_counters("reset");
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_frame(128, -1, 0, 1'b1);
        exp_frames++;
        wait_idle("basic", 400);
        check_counters("basic");
    endtask

    task automatic test_delay();
        send_frame(128, -1, 100, 1'b1);
        exp_frames++;
        wait_idle("delay100", 500);
        check_counters("delay100");
        send_frame(128, -1, 10, 1'b1);
        exp_frames++;
        wait_idle("delay10", 400);
        check_counters("delay10");
        send_frame(20, -1, 255, 1'b1);
        exp_frames++;
        wait_idle("delay255", 500);
        check_counters("delay255");
    endtask

    task automatic test_tx_er();
        send_frame(128, 10, 0, 1'b1);
        tx_er = 1'b1;
        exp_frames++;
        wait_idle("tx_er", 400);
        tx_er = 1'b0;
        check_counters("tx_er");
        send_frame(1, 0, 0, 1'b1);
        exp_frames++;
        wait_idle("single", 200);
        check_counters("single");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4100; i++) begin
            @(negedge clk);
            tx_en = 1'b1;
            txd = 4'(i);
        end
        @(negedge clk);
        tx_en = 1'b0;
        exp_drops++;
        wait_idle("overflow", 300);
        check_counters("overflow");
    endtask

    task automatic test_back_to_back();
        send_frame(60, -1, 30, 1'b1);
        exp_frames++;
        wait_rx_dv("b2b", 200);
        repeat (5) @(negedge clk);
        send_frame(80, -1, 0, 1'b0);
        exp_drops++;
        wait_idle("b2b", 400);
        check_counters("b2b");
        send_frame(50, 3, 0, 1'b1);
        exp_frames++;
        wait_idle("b2b_third", 300);
        check_counters("b2b_third");
        send_frame(30, -1, 40, 1'b1);
        exp_frames++;
        repeat (10) @(negedge clk);
        send_frame(4, -1, 0, 1'b0);
        exp_drops++;
        wait_idle("wait_drop", 300);
        check_counters("wait_drop");
    endtask

    task automatic test_reset_mid();
        send_frame(100, -1, 0, 1'b1);
        wait_rx_dv("rst_mid", 200);
        repeat (10) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        vectors++;
        if ({rx_dv, rxd, rx_er} !== 6'd0) begin
            miscompares++;
            $display("FAIL rst_mid_rx: got {dv,d,er}=%h, expected 0", {rx_dv, rxd, rx_er});
        end
        exp_q.delete();
        start_q.delete();
        blen_q.delete();
        mon_prev_dv = 1'b0;
        mon_burst = 0;
        exp_frames = 0;
        exp_drops = 0;
        check_counters("rst_mid");
        @(negedge clk);
        arst = 1'b0;
        send_frame(40, 7, 0, 1'b1);
        exp_frames++;
        wait_idle("rst_recover", 300);
        check_counters("rst_recover");
    endtask

`ifdef ETHMAC_LB_ERR_INJ_EN
    task automatic test_err_inj();
        inj_en = 1'b1;
        inj_idx = 12'd5;
        send_frame(40, -1, 0, 1'b1);
        exp_frames++;
        wait_idle("err_inj", 300);
        inj_en = 1'b0;
        check_counters("err_inj");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_tx_er();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef ETHMAC_LB_ERR_INJ_EN
        test_err_inj();
`endif
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
